// File: rtl/iobus_arbiter_if.sv
// Bundle of requester, grant/ack and MMIO bus signals shared by the arbiter and its users.
// Handshake: a requester raises REQn with ADDRn/WRn/WDATAn stable; GNTn shows bus ownership and
// a one-cycle ACKn closes the transaction (RDATA valid during that ACK). REQn held past ACKn starts a new one.
interface iobus_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic        WR0;
  logic        WR1;
  logic [31:0] ADDR0;
  logic [31:0] ADDR1;
  logic [31:0] WDATA0;
  logic [31:0] WDATA1;
  logic        GNT0;
  logic        GNT1;
  logic        ACK0;
  logic        ACK1;
  logic [31:0] RDATA;
  logic [31:0] IOBUS_addr;
  logic [31:0] IOBUS_out;
  logic        IOBUS_wr;
  logic [31:0] IOBUS_in;

  modport master (
    output REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1, IOBUS_in,
    input  GNT0, GNT1, ACK0, ACK1, RDATA, IOBUS_addr, IOBUS_out, IOBUS_wr
  );

  modport slave (
    input  REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1, IOBUS_in,
    output GNT0, GNT1, ACK0, ACK1, RDATA, IOBUS_addr, IOBUS_out, IOBUS_wr
  );
endinterface

// File: rtl/iobus_arbiter.sv
// Two-requester round-robin arbiter for a single MMIO bus with a programmable number of wait states.
// Each transaction runs IDLE -> BUS (WAIT_STATES+1 cycles) -> ACK (1 cycle) -> IDLE.
module iobus_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           CLK,
  input  logic           RST_N,
  iobus_arbiter_if.slave bus,
  output logic [1:0]     state_o,
  output logic           ptr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q;
  logic        ptr_q;
  logic [3:0]  cnt_q;
  logic        win_q;
  logic        wr_q;
  logic        gnt0_q, gnt1_q;
  logic        ack0_q, ack1_q;
  logic        iobus_wr_q;
  logic [31:0] addr_q, out_q, rdata_q;

  logic        win_d;
  logic        wr_d;
  logic [31:0] addr_d, out_d;
  logic        other_req;

  // Contention goes to the preferred requester; otherwise whoever is asking wins.
  always_comb begin
    win_d = bus.REQ1;
    if (bus.REQ0 && bus.REQ1) win_d = ptr_q;
    wr_d      = win_d ? bus.WR1    : bus.WR0;
    addr_d    = win_d ? bus.ADDR1  : bus.ADDR0;
    out_d     = win_d ? bus.WDATA1 : bus.WDATA0;
    other_req = win_q ? bus.REQ0   : bus.REQ1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= 4'd0;
      win_q      <= 1'b0;
      wr_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      iobus_wr_q <= 1'b0;
      addr_q     <= 32'd0;
      out_q      <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            win_q      <= win_d;
            wr_q       <= wr_d;
            gnt0_q     <= ~win_d;
            gnt1_q     <= win_d;
            addr_q     <= addr_d;
            out_q      <= out_d;
            iobus_wr_q <= wr_d;
            cnt_q      <= WS;
            state_q    <= BUS;
          end
        end
        BUS: begin
          iobus_wr_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            if (!wr_q) rdata_q <= bus.IOBUS_in;
            ack0_q  <= ~win_q;
            ack1_q  <= win_q;
            // Only hand preference over when the other side is actually waiting.
            if (other_req) ptr_q <= ~win_q;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.GNT0       = gnt0_q;
  assign bus.GNT1       = gnt1_q;
  assign bus.ACK0       = ack0_q;
  assign bus.ACK1       = ack1_q;
  assign bus.RDATA      = rdata_q;
  assign bus.IOBUS_addr = addr_q;
  assign bus.IOBUS_out  = out_q;
  assign bus.IOBUS_wr   = iobus_wr_q;
  assign state_o        = state_q;
  assign ptr_o          = ptr_q;

endmodule

// File: doc/iobus_arbiter.md
IOBUS_ARBITER -- requirements
Module: iobus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, giving extra bus cycles per transaction for slow MMIO peripherals (range 0-15).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports REQ0/REQ1  input  1  requester 0 (MCU) / requester 1 (debug/DMA) transaction request.
REQ-005 SHALL have ports WR0/WR1  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports ADDR0/ADDR1  input  32  MMIO address, e.g. 0x11080000 for LEDS.
REQ-007 SHALL have ports WDATA0/WDATA1  input  32  write data.
REQ-008 SHALL have ports GNT0/GNT1  output  1  requester owns the bus.
REQ-009 SHALL have ports ACK0/ACK1  output  1  one-cycle transaction-complete pulse.
REQ-010 SHALL have port RDATA  output  32  read data, valid during an ACK pulse.
REQ-011 SHALL have ports IOBUS_addr / IOBUS_out  output  32  registered MMIO address / write data.
REQ-012 SHALL have port IOBUS_wr  output  1  registered write strobe.
REQ-013 SHALL have port IOBUS_in  input  32  combinational MMIO read data.

Function
REQ-014 SHALL implement the FSM states IDLE, BUS and ACK.
REQ-015 IDLE: with no REQ asserted, the FSM SHALL stay in IDLE.
REQ-016 IDLE: with any REQ asserted, the FSM SHALL choose a winner, latch its ADDR/WDATA/WR onto IOBUS_addr/IOBUS_out, assert the winner's GNT and go to BUS.
REQ-017 Arbitration SHALL be round-robin: a 1-bit pointer marks the preferred requester, and on simultaneous REQ0 and REQ1 the preferred one wins.
REQ-018 The pointer SHALL move to the other requester when a grant's ACK is issued, and SHALL NOT move when only one requester is active.
REQ-019 BUS SHALL last WAIT_STATES+1 cycles, counted by a 4-bit down-counter loaded with WAIT_STATES on entry.
REQ-020 IOBUS_wr SHALL be high for exactly the first BUS cycle on writes, and SHALL stay 0 on reads.
REQ-021 On the final BUS cycle the block SHALL capture IOBUS_in into RDATA for reads, and SHALL leave RDATA unchanged for writes.
REQ-022 ACK SHALL last 1 cycle: the winner's ACK pulses high and its GNT stays high, then the FSM returns to IDLE and both GNTs drop.
REQ-023 Latency SHALL be: REQ sampled in IDLE at edge t, IOBUS_* valid after t, ACK high in cycle t+2+WAIT_STATES.
REQ-024 Requesters SHALL hold ADDR/WR/WDATA stable from REQ until ACK; the block SHALL latch them at grant and SHALL ignore later changes.
REQ-025 A REQ still high in the IDLE cycle after its ACK SHALL be treated as a new transaction, so back-to-back throughput is one transaction per WAIT_STATES+3 cycles.
REQ-026 The loser of a simultaneous request SHALL NOT lose its pending request; it SHALL be granted on the next IDLE.
REQ-027 REQ deasserted during BUS or ACK SHALL NOT abort the transaction; it SHALL complete and ACK is still issued.
REQ-028 GNT0 and GNT1 SHALL never be high together, and ACK0 and ACK1 SHALL never be high together.
REQ-029 IOBUS_addr and IOBUS_out SHALL hold their last values in IDLE; there SHALL be no spurious IOBUS_wr.

Reset
REQ-030 RST_N low SHALL immediately force state IDLE, pointer 0, wait counter 0, GNT0/1=0, ACK0/1=0, IOBUS_wr=0, IOBUS_addr=0, IOBUS_out=0 and RDATA=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no ACK.
REQ-032 Release of RST_N SHALL take effect on the first CLK edge after deassertion; it SHALL be synchronised externally.

Verification
REQ-033 The bench SHALL cover: REQ0 write addr 0x11080000 data 0x0000A5A5, WAIT_STATES=0 -> IOBUS_wr high 1 cycle with that addr/data, ACK0 two cycles after request, GNT1 never high.
REQ-034 The bench SHALL cover: REQ1 read 0x11000000 with IOBUS_in=0x00001234 -> RDATA=0x00001234 during the ACK1 pulse, IOBUS_wr stays 0.
REQ-035 The bench SHALL cover: REQ0 and REQ1 raised in the same cycle after reset, both held -> order 0,1,0,1, with ACKs every 3 cycles.
REQ-036 The bench SHALL cover: WAIT_STATES=3, write -> IOBUS_wr high 1 cycle, BUS lasts 4 cycles, ACK at t+5.
REQ-037 The bench SHALL cover: RST_N low during BUS of a write -> all outputs 0 immediately, no ACK, and after release REQ0 is served with pointer 0.
REQ-038 The bench SHALL cover: REQ0 dropped during BUS -> ACK0 still pulses once, then FSM in IDLE with GNT0=0.
